data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Responder side of the processor data-memory interface: word-addressed RAM
//   serving load/store requests with a valid/ready handshake and a fixed,
//   parameterised wait-state latency. Sits between the processor's
//   alu_out/write_data/mem_write outputs and its read_data input.
//   Lets the multi-cycle/stalling core be exercised against realistic memory timing.
// PARAMETERS
//   DEPTH    64  number of 32-bit words; power of two, 4..1024
//   LATENCY  2   wait cycles between accept and response, 0..15
// PORTS
//   clk         in   1   single clock; all state updates on rising edge
//   reset       in   1   synchronous, active-high
//   req_valid   in   1   request present (addr, mem_write, write_data valid)
//   req_ready   out  1   responder can accept a request this cycle
//   mem_write   in   1   1 = store, 0 = load; sampled at accept
//   alu_out     in   32  byte address; sampled at accept
//   write_data  in   32  store data; sampled at accept
//   resp_valid  out  1   one-cycle pulse: access complete
//   read_data   out  32  load result; valid when resp_valid=1, held until next response
//   misaligned  out  1   qualifies resp_valid: addr[1:0] != 0, access suppressed
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1, resp_valid=0, read_data=0, misaligned=0.
//     RAM contents not reset; a load from an unwritten word returns X.
//   - Accept = req_valid & req_ready at a rising edge; addr/we/data latched.
//   - Word index = alu_out[log2(DEPTH)+1:2]; upper bits ignored (addresses alias).
//   - FSM states IDLE, WAIT, RESP:
//       IDLE: req_ready=1. On accept: LATENCY>0 -> WAIT, cnt=LATENCY-1;
//             LATENCY=0 -> RESP.
//       WAIT: req_ready=0; requests ignored. cnt!=0 -> cnt-1; cnt=0 -> RESP.
//       RESP: resp_valid=1 for exactly one cycle; req_ready=1.
//             Accept here -> WAIT/RESP as from IDLE (back-to-back);
//             otherwise -> IDLE.
//   - Latency: resp_valid asserted LATENCY+1 cycles after the accept edge.
//     Max throughput is one request per LATENCY+1 cycles.
//   - Access is performed on the edge entering RESP:
//       store: RAM[idx] <= data; read_data <= 0.
//       load:  read_data <= RAM[idx].
//     Load-after-store to the same word returns the stored value.
//   - Misaligned (addr[1:0]!=0): no RAM write; read_data <= 0; misaligned=1 in RESP.
//     misaligned is 0 in every other cycle.
//   - req_valid deasserted after accept has no effect on the pending request.
//   - Reset mid-operation (WAIT or RESP): pending request dropped; a pending store
//     is NOT written; outputs return to reset values on the next edge.
//   - Inputs are don't-care whenever req_valid=0 or req_ready=0.
// TESTING
//   1. Reset, LATENCY=2; store 0xDEADBEEF @0x10, then load @0x10
//      -> each resp_valid 3 cycles after accept; load read_data=0xDEADBEEF.
//   2. LATENCY=0; back-to-back stores @0x0 and @0x4, then loads issued in RESP
//      -> a response every cycle; loads return the stored values.
//   3. Load @0x13 after storing 0x12345678 @0x10
//      -> misaligned=1, read_data=0; word @0x10 still 0x12345678.
//   4. DEPTH=64: store 0xA5A5A5A5 @0x100, load @0x0 -> 0xA5A5A5A5 (alias wrap).
//   5. Store 0x1 @0x20 accepted, reset asserted in WAIT -> no resp_valid,
//      req_ready=1; prior 0x0 @0x20 still reads 0x0.
//   6. req_valid held high during WAIT with changing addr -> ignored; only the
//      latched request completes, one resp_valid pulse.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a valid/ready request port with a fixed,
// parameterised wait-state latency before each one-cycle response pulse.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] CntInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            mis_q, mis_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            mis_out_q, mis_out_d;

  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            in_mis;
  logic [AW-1:0]   in_idx;
  logic            acc_en, acc_we, acc_mis;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;

  // Upper address bits alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^alu_out[31:AW+2];

  assign req_ready  = (state_q != StWait);
  assign resp_valid = (state_q == StResp);
  assign read_data  = read_data_q;
  assign misaligned = mis_out_q;

  assign accept = req_valid & req_ready;
  assign in_mis = |alu_out[1:0];
  assign in_idx = alu_out[AW+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    mis_d     = mis_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_mis   = 1'b0;
    acc_idx   = '0;
    acc_wdata = '0;

    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          we_d    = mem_write;
          mis_d   = in_mis;
          idx_d   = in_idx;
          wdata_d = write_data;
          if (LATENCY == 0) begin
            // Zero wait states: the access happens on the accept edge itself.
            state_d   = StResp;
            acc_en    = 1'b1;
            acc_we    = mem_write;
            acc_mis   = in_mis;
            acc_idx   = in_idx;
            acc_wdata = write_data;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end else if (state_q == StResp) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d   = StResp;
          acc_en    = 1'b1;
          acc_we    = we_q;
          acc_mis   = mis_q;
          acc_idx   = idx_q;
          acc_wdata = wdata_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    read_data_d = read_data_q;
    mis_out_d   = 1'b0;
    if (acc_en) begin
      mis_out_d   = acc_mis;
      read_data_d = (acc_we || acc_mis) ? 32'd0 : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      mis_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      mis_out_q   <= mis_out_d;
    end
  end

  // RAM has no reset; a store pending when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!reset && acc_en && acc_we && !acc_mis) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

endmodule
